// File: rtl/video_timing_pkg.sv
// Shared raster-timing types and constants for the pixel-clock domain.
// Defaults describe 1024x768@60 at a 65 MHz pixel clock.
package video_timing_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        SETTLE,
        RUN
    } state_t;

    localparam int XGA_H_ACTIVE = 1024;
    localparam int XGA_H_FP     = 24;
    localparam int XGA_H_SYNC   = 136;
    localparam int XGA_H_BP     = 160;
    localparam int XGA_V_ACTIVE = 768;
    localparam int XGA_V_FP     = 3;
    localparam int XGA_V_SYNC   = 6;
    localparam int XGA_V_BP     = 29;

    function automatic int total(input int act, input int fp,
                                 input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Raster output bundle from the timing generator to the encoder
// and the frame-buffer read path.
interface video_timing_gen_if #(
    parameter int CW = 12
);
    logic          hs;
    logic          vs;
    logic          de;
    logic          req_de;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          line_start;
    logic          frame_start;
    logic          running;

    modport master (
        output hs, vs, de, req_de, x, y,
        output line_start, frame_start, running
    );

    modport slave (
        input hs, vs, de, req_de, x, y,
        input line_start, frame_start, running
    );
endinterface

// File: rtl/video_timing_gen_sync_2ff.sv
// Generic 1-bit two-flop synchroniser with synchronous clear.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: waits for a settled PLL lock, then runs
// h/v counters and emits registered sync, enable and coordinate outputs.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int   H_ACTIVE  = XGA_H_ACTIVE,
    parameter int   H_FP      = XGA_H_FP,
    parameter int   H_SYNC    = XGA_H_SYNC,
    parameter int   H_BP      = XGA_H_BP,
    parameter int   V_ACTIVE  = XGA_V_ACTIVE,
    parameter int   V_FP      = XGA_V_FP,
    parameter int   V_SYNC    = XGA_V_SYNC,
    parameter int   V_BP      = XGA_V_BP,
    parameter logic HS_POL    = 1'b0,
    parameter logic VS_POL    = 1'b0,
    parameter int   LOCK_WAIT = 1024,
    parameter int   REQ_LEAD  = 2,
    parameter int   CW        = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_lock,
    video_timing_gen_if.master vid
);
    localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC;
    localparam int LCW     = $clog2(LOCK_WAIT) + 1;

    logic           lock_s;
    state_t         state, state_nx;
    logic [LCW-1:0] lock_cnt;
    logic [CW-1:0]  h_cnt, v_cnt;
    logic           run_hold;
    logic           h_last, v_last;
    logic [CW:0]    h_sum;
    logic [CW-1:0]  h_ahead, v_ahead;
    logic           act, act_ahead, hs_on, vs_on;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_LOCK;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            WAIT_LOCK: if (lock_s) state_nx = SETTLE;
            SETTLE: begin
                if (!lock_s)
                    state_nx = WAIT_LOCK;
                else if (lock_cnt == LCW'(LOCK_WAIT - 1))
                    state_nx = RUN;
            end
            RUN:       if (!lock_s) state_nx = WAIT_LOCK;
            default:   state_nx = WAIT_LOCK;
        endcase
    end

    // Outputs load a live decode only while RUN continues across the edge,
    // so the cycle after leaving RUN is already idle.
    always_comb begin
        vid.running = (state == RUN);
        run_hold    = (state == RUN) && (state_nx == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst || state != SETTLE) lock_cnt <= '0;
        else                        lock_cnt <= lock_cnt + 1'b1;
    end

    assign h_last = (h_cnt == CW'(H_TOTAL - 1));
    assign v_last = (v_cnt == CW'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (rst || !run_hold) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Position REQ_LEAD pixels ahead, wrapping across line and frame.
    always_comb begin
        h_sum   = {1'b0, h_cnt} + (CW+1)'(REQ_LEAD);
        h_ahead = h_sum[CW-1:0];
        v_ahead = v_cnt;
        if (h_sum >= (CW+1)'(H_TOTAL)) begin
            h_ahead = CW'(h_sum - (CW+1)'(H_TOTAL));
            v_ahead = v_last ? '0 : v_cnt + 1'b1;
        end
    end

    assign act       = (h_cnt < CW'(H_ACTIVE)) && (v_cnt < CW'(V_ACTIVE));
    assign act_ahead = (h_ahead < CW'(H_ACTIVE)) && (v_ahead < CW'(V_ACTIVE));
    assign hs_on     = (h_cnt >= CW'(HS_BEG)) && (h_cnt < CW'(HS_END));
    assign vs_on     = (v_cnt >= CW'(VS_BEG)) && (v_cnt < CW'(VS_END));

    always_ff @(posedge clk) begin
        if (rst || !run_hold) begin
            vid.hs          <= ~HS_POL;
            vid.vs          <= ~VS_POL;
            vid.de          <= 1'b0;
            vid.req_de      <= 1'b0;
            vid.x           <= '0;
            vid.y           <= '0;
            vid.line_start  <= 1'b0;
            vid.frame_start <= 1'b0;
        end else begin
            vid.hs          <= hs_on ? HS_POL : ~HS_POL;
            vid.vs          <= vs_on ? VS_POL : ~VS_POL;
            vid.de          <= act;
            vid.req_de      <= act_ahead;
            vid.x           <= act ? h_cnt : '0;
            vid.y           <= act ? v_cnt : '0;
            vid.line_start  <= act && (h_cnt == '0);
            vid.frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end
endmodule

// File: tb/tb_video_timing_gen.sv
// Randomised lock/reset stimulus against an arithmetic raster model,
// with a queue-based scoreboard checked every pixel clock.
module tb_video_timing_gen;
    localparam int   HA = 8, HFP = 2, HSW = 3, HBP = 3;
    localparam int   VA = 4, VFP = 1, VSW = 2, VBP = 1;
    localparam int   HT = HA + HFP + HSW + HBP;
    localparam int   VT = VA + VFP + VSW + VBP;
    localparam int   FR = HT * VT;
    localparam int   LW = 16;
    localparam int   LEAD = 2;
    localparam int   CW = 12;
    localparam logic HP = 1'b0;
    localparam logic VP = 1'b0;

    typedef logic [7+2*CW-1:0] vec_t;

    logic clk = 1'b0;
    logic rst;
    logic pll_lock;

    video_timing_gen_if #(.CW(CW)) vif ();

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(HP), .VS_POL(VP), .LOCK_WAIT(LW),
        .REQ_LEAD(LEAD), .CW(CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pll_lock (pll_lock),
        .vid      (vif)
    );

    always #5 clk = ~clk;

    vec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model: lock seen through two flops; raster runs once the synchronised
    // lock has been high for LW+1 edges, outputs one edge after that.
    int   hi_len = 0;
    logic s1 = 1'b0, s2 = 1'b0;

    function automatic logic in_act(input int p);
        return (p % HT) < HA && (p / HT) < VA;
    endfunction

    function automatic vec_t expect_now();
        int   pos, p, h, v;
        logic a, run;
        run = hi_len >= LW + 1;
        if (hi_len < LW + 2)
            return {run, ~HP, ~VP, 4'b0000, {CW{1'b0}}, {CW{1'b0}}};
        pos = hi_len - LW - 2;
        p   = pos % FR;
        h   = p % HT;
        v   = p / HT;
        a   = in_act(p);
        return {1'b1,
                (h >= HA + HFP && h < HA + HFP + HSW) ? HP : ~HP,
                (v >= VA + VFP && v < VA + VFP + VSW) ? VP : ~VP,
                a, in_act((pos + LEAD) % FR),
                a && h == 0, p == 0,
                a ? CW'(h) : {CW{1'b0}},
                a ? CW'(v) : {CW{1'b0}}};
    endfunction

    task automatic step(input logic r, input logic l);
        @(negedge clk);
        rst      = r;
        pll_lock = l;
        if (r) begin
            hi_len = 0;
            s1 = 1'b0;
            s2 = 1'b0;
        end else begin
            hi_len = s2 ? hi_len + 1 : 0;
            s2 = s1;
            s1 = l;
        end
        sb.push_back(expect_now());
    endtask

    task automatic hold(input logic r, input logic l, input int n);
        for (int i = 0; i < n; i++) step(r, l);
    endtask

    always @(posedge clk) begin
        vec_t exp_v, act_v;
        #1;
        if (sb.size() > 0) begin
            exp_v = sb.pop_front();
            act_v = {vif.running, vif.hs, vif.vs, vif.de, vif.req_de,
                     vif.line_start, vif.frame_start, vif.x, vif.y};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL raster t=%0t act=%h exp=%h", $time, act_v, exp_v);
            end
        end
    end

    initial begin
        logic l;
        rst      = 1'b1;
        pll_lock = 1'b0;
        hold(1'b1, 1'b0, 3);
        hold(1'b0, 1'b1, LW + 3 + 2 * FR + 20);
        hold(1'b0, 1'b0, 5);
        hold(1'b0, 1'b1, 10);
        hold(1'b0, 1'b0, 1);
        hold(1'b0, 1'b1, LW + 3 + FR + 40);
        hold(1'b0, 1'b0, 4);
        hold(1'b0, 1'b1, 200);
        hold(1'b1, 1'b1, 2);
        hold(1'b0, 1'b1, 200);
        l = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) l = ~l;
            step($urandom_range(0, 499) == 0, l);
        end
        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain left=%0d exp=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
